pla_root_stream: RTL and testbench
==================================

PLA_ROOT_STREAM -- requirements
Module: pla_root_stream

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning input FIFO entries; legal values are powers of two, 2 to 16.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port flush, input, 1 bit: synchronous clear of all queued and held data.
REQ-005 The module SHALL have port in_valid, input, 1 bit: upstream offers in_data.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the module can accept in_data this cycle.
REQ-007 The module SHALL have port in_data, input, 8 bits: operand; bit i maps to PLA input xi.
REQ-008 The module SHALL have port pla_x, output, 8 bits: operand driven to the external root PLA (x0 = bit 0).
REQ-009 The module SHALL have port pla_z, input, 5 bits: combinational PLA result (z0 = bit 0) for the current pla_x.
REQ-010 The module SHALL have port out_valid, output, 1 bit: out_data holds a result.
REQ-011 The module SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-012 The module SHALL have port out_data, output, 5 bits: registered PLA result.
REQ-013 The module SHALL have port out_src, output, 8 bits: the operand that produced out_data.
REQ-014 The module SHALL have port level, output, clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-015 The module SHALL have port out_count, output, 16 bits: completed output handshakes, wrapping modulo 2^16.

Function
REQ-016 The module SHALL accept an input on a rising edge where in_valid and in_ready are both 1, writing in_data to the FIFO tail.
REQ-017 The module SHALL drive in_ready = 1 exactly when level < DEPTH and flush = 0; there is no same-cycle full bypass.
REQ-018 The module SHALL drive pla_x with the FIFO head entry when level > 0, and with 8'h00 when level = 0.
REQ-019 The module SHALL issue the head when level > 0 and the output register is empty or out_ready = 1: on that edge it pops the head, loads out_data from pla_z and out_src from pla_x, and sets out_valid to 1.
REQ-020 The module SHALL clear out_valid on an edge where out_valid = 1, out_ready = 1 and no issue occurs.
REQ-021 The module SHALL hold out_data and out_src stable while out_valid = 1 and out_ready = 0.
REQ-022 Latency SHALL be: an input accepted at edge N into an empty FIFO with an empty output register appears with out_valid = 1 after edge N+1.
REQ-023 Throughput SHALL be one result per cycle when in_valid and out_ready are held at 1.
REQ-024 A push and a pop in the same edge SHALL leave level unchanged; a push while full SHALL NOT occur, because in_ready is 0.
REQ-025 FIFO read and write pointers SHALL wrap modulo DEPTH without loss or duplication of entries.
REQ-026 out_count SHALL increment by 1 on each edge with out_valid = 1 and out_ready = 1, and wrap from 16'hFFFF to 16'h0000.
REQ-027 When flush = 1 at an edge, the module SHALL empty the FIFO (level becomes 0), set out_valid to 0, and discard any input and any issue on that edge; out_count is not changed.
REQ-028 When flush = 1 and an output handshake occur on the same edge, the handshake SHALL count in out_count, and the data is lost.
REQ-029 The module SHALL deliver results in strict acceptance order.

Reset
REQ-030 While rst_n = 0, the module SHALL force: level = 0, out_valid = 0, out_data = 5'h00, out_src = 8'h00, out_count = 16'h0000, pla_x = 8'h00, in_ready = 0.
REQ-031 After rst_n rises, in_ready SHALL be 1 from the first cycle in which flush = 0.
REQ-032 Reset asserted mid-operation SHALL discard all queued and held data immediately, without waiting for a clock edge.

Verification
REQ-033 Single operand: with a bench PLA model, out_ready = 1, push 8'hFF -> pla_x = 8'hFF the next cycle; after the following edge out_valid = 1, out_data = model(8'hFF), out_src = 8'hFF, out_count = 1.
REQ-034 Backpressure: DEPTH = 4, out_ready = 0, push 8'h01 to 8'h06 -> the first result is held in the output register, level reaches 4, in_ready = 0; then out_ready = 1 -> results arrive in order 01..05 with held data stable, and 06 is accepted when space frees.
REQ-035 Streaming: 64 back-to-back operands 8'h00 to 8'h3F with out_ready = 1 -> 64 consecutive out_valid cycles, each out_data matching the model, out_count = 64.
REQ-036 Flush: level = 3 and out_valid = 1, then assert flush with in_valid = 1 for one cycle -> next cycle level = 0, out_valid = 0, pla_x = 8'h00, and the flushed input never appears at the output.
REQ-037 Async reset: drop rst_n between clock edges with level = 2 -> all outputs reach their reset values immediately; after release, a push of 8'hA5 yields out_src = 8'hA5 as the first result.
REQ-038 Counter wrap: preload via 65535 handshakes, then one more -> out_count = 16'h0000.

Source files
------------

// File: rtl/pla_root_stream_if.sv
// pla_root_stream_if
// Bundles the stream handshakes, the external PLA operand/result pair, flush
// and the status outputs of pla_root_stream.
//   slave  modport : the pla_root_stream core side
//   master modport : the surrounding system (upstream, downstream, PLA)
// Signals:
//   flush                      synchronous clear of queued and held data
//   in_valid/in_ready/in_data  8-bit operand stream into the FIFO
//   pla_x / pla_z              operand to and result from the external PLA
//   out_valid/out_ready/out_data/out_src  registered result stream
//   level                      FIFO occupancy, clog2(DEPTH)+1 bits
//   out_count                  completed output handshakes, mod 2^16
interface pla_root_stream_if #(
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic [7:0]       pla_x;
    logic [4:0]       pla_z;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_data;
    logic [7:0]       out_src;
    logic [LVL_W-1:0] level;
    logic [15:0]      out_count;

    modport slave (
        input  flush, in_valid, in_data, pla_z, out_ready,
        output in_ready, pla_x, out_valid, out_data, out_src, level, out_count
    );

    modport master (
        output flush, in_valid, in_data, pla_z, out_ready,
        input  in_ready, pla_x, out_valid, out_data, out_src, level, out_count
    );
endinterface

// File: rtl/pla_root_stream.sv
// pla_root_stream
// Queues 8-bit operands in a DEPTH-entry FIFO, presents the head entry to an
// external combinational PLA on pla_x, and captures the PLA result together
// with its operand into a one-entry output register.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pla_root_stream_if.slave (flush, input stream, PLA pair, output
//          stream, level, out_count)
module pla_root_stream #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    pla_root_stream_if.slave   bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic             r_out_vld_p1;
    logic [4:0]       r_out_data_p1;
    logic [7:0]       r_out_src_p1;
    logic [15:0]      r_out_count;

    logic             w_empty;
    logic             w_full;
    logic             w_in_ready;
    logic             w_push;
    logic             w_issue;
    logic             w_out_hs;
    logic [7:0]       w_head;

    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == LVL_W'(DEPTH));
    // rst_n gates in_ready so the upstream sees "not ready" for the whole
    // reset window, not only after the first clock edge.
    assign w_in_ready = rst_n & ~w_full & ~bus.flush;
    assign w_push     = bus.in_valid & w_in_ready;
    // Issue whenever the output slot is free or is being drained this edge;
    // flush suppresses it so nothing new is captured while clearing.
    assign w_issue    = ~w_empty & (~r_out_vld_p1 | bus.out_ready) & ~bus.flush;
    assign w_out_hs   = r_out_vld_p1 & bus.out_ready;
    // An empty FIFO shows zero to the PLA rather than a stale entry.
    assign w_head     = w_empty ? 8'h00 : r_mem[r_rd_ptr];

    // ---- stage p0: FIFO storage and occupancy ----
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_issue})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ---- stage p1: output register (PLA result + source operand) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld_p1  <= 1'b0;
            r_out_data_p1 <= 5'h00;
            r_out_src_p1  <= 8'h00;
        end else if (bus.flush) begin
            r_out_vld_p1  <= 1'b0;
        end else if (w_issue) begin
            r_out_vld_p1  <= 1'b1;
            r_out_data_p1 <= bus.pla_z;
            r_out_src_p1  <= w_head;
        end else if (w_out_hs) begin
            r_out_vld_p1  <= 1'b0;
        end
    end

    // A handshake completing on a flush edge still counts: the downstream
    // did take the word, even though the core clears its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_count <= 16'h0000;
        end else if (w_out_hs) begin
            r_out_count <= r_out_count + 16'h0001;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.pla_x     = w_head;
    assign bus.out_valid = r_out_vld_p1;
    assign bus.out_data  = r_out_data_p1;
    assign bus.out_src   = r_out_src_p1;
    assign bus.level     = r_level;
    assign bus.out_count = r_out_count;
endmodule

// File: tb/tb_pla_root_stream.sv
// tb_pla_root_stream
// Drives pla_root_stream (DEPTH = 4) with directed and random traffic, models
// the external PLA, and checks results against an in-order scoreboard.
module tb_pla_root_stream;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pla_root_stream_if #(.DEPTH(4)) bus ();
    pla_root_stream #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Reference PLA: a fixed set of sum-of-products style functions.
    function automatic logic [4:0] pla_fn(input logic [7:0] x);
        logic [4:0] z;
        z[0] = (x[0] & x[1]) | (x[2] & ~x[3]);
        z[1] = ^x;
        z[2] = (x[7:4] > x[3:0]);
        z[3] = x[7] | (x[6] & x[5]);
        z[4] = ~(x[0] | x[4]);
        return z;
    endfunction

    assign bus.pla_z = pla_fn(bus.pla_x);

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard: operands accepted but not yet delivered, plus the pairs
    // (expected operand, delivered word) gathered at each output handshake.
    logic [7:0]  exp_q [$];
    logic [8:0]  del_q [$];   // bit 8 set: handshake with nothing pending
    logic [12:0] got_q [$];   // {out_src, out_data}
    logic [15:0] exp_cnt = 16'h0000;

    always @(posedge clk) begin
        logic [7:0] head;
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back({bus.out_src, bus.out_data});
                if (exp_q.size() > 0) begin
                    head = exp_q.pop_front();
                    del_q.push_back({1'b0, head});
                end else begin
                    del_q.push_back(9'h100);
                end
                exp_cnt = exp_cnt + 16'h0001;
            end
            if (bus.flush) exp_q.delete();
            else if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
        end
    end

    always @(negedge rst_n) begin
        exp_q.delete();
        exp_cnt = 16'h0000;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) cyc();
        n_vec++; if (bus.level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d, expected 0", bus.level); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
        n_vec++; if (bus.out_data !== 5'h00) begin n_err++; $display("FAIL reset_out_data: got %h, expected 00", bus.out_data); end
        n_vec++; if (bus.out_src !== 8'h00) begin n_err++; $display("FAIL reset_out_src: got %h, expected 00", bus.out_src); end
        n_vec++; if (bus.out_count !== 16'h0000) begin n_err++; $display("FAIL reset_out_count: got %h, expected 0000", bus.out_count); end
        n_vec++; if (bus.pla_x !== 8'h00) begin n_err++; $display("FAIL reset_pla_x: got %h, expected 00", bus.pla_x); end
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b, expected 0", bus.in_ready); end
        rst_n = 1'b1;
        #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b, expected 1", bus.in_ready); end
        cyc();
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'hFF;
        cyc();
        bus.in_valid = 1'b0;
        n_vec++; if (bus.pla_x !== 8'hFF) begin n_err++; $display("FAIL single_pla_x: got %h, expected ff", bus.pla_x); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b, expected 0", bus.out_valid); end
        cyc();
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid: got %b, expected 1", bus.out_valid); end
        n_vec++; if (bus.out_data !== pla_fn(8'hFF)) begin n_err++; $display("FAIL single_out_data: got %h, expected %h", bus.out_data, pla_fn(8'hFF)); end
        n_vec++; if (bus.out_src !== 8'hFF) begin n_err++; $display("FAIL single_out_src: got %h, expected ff", bus.out_src); end
        cyc();
        n_vec++; if (bus.out_count !== 16'd1) begin n_err++; $display("FAIL single_out_count: got %0d, expected 1", bus.out_count); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_drained: got %b, expected 0", bus.out_valid); end
        for (int i = 0; i < got_q.size(); i++) begin
            n_vec++;
            if (del_q[i][8] || got_q[i] !== {del_q[i][7:0], pla_fn(del_q[i][7:0])}) begin
                n_err++; $display("FAIL single_result[%0d]: got src=%h data=%h, expected src=%h data=%h", i, got_q[i][12:5], got_q[i][4:0], del_q[i][7:0], pla_fn(del_q[i][7:0]));
            end
        end
        got_q.delete(); del_q.delete();
    endtask

    task automatic test_backpressure();
        logic acc;
        logic [7:0] v;
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'(k);
            cyc();
        end
        bus.in_data = 8'h06;
        for (int h = 0; h < 3; h++) begin
            cyc();
            n_vec++; if (bus.level !== 3'd4) begin n_err++; $display("FAIL bp_level: got %0d, expected 4", bus.level); end
            n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b, expected 0", bus.in_ready); end
            n_vec++; if (bus.out_valid !== 1'b1 || bus.out_src !== 8'h01 || bus.out_data !== pla_fn(8'h01)) begin
                n_err++; $display("FAIL bp_held: got valid=%b src=%h data=%h, expected valid=1 src=01 data=%h", bus.out_valid, bus.out_src, bus.out_data, pla_fn(8'h01));
            end
        end
        bus.out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = bus.in_ready;
            cyc();
        end
        n_vec++; if (!acc) begin n_err++; $display("FAIL bp_accept_06: got no acceptance in 20 cycles, expected acceptance"); end
        bus.in_valid = 1'b0;
        repeat (10) cyc();
        n_vec++; if (got_q.size() != 6) begin n_err++; $display("FAIL bp_count: got %0d results, expected 6", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            v = 8'(i + 1);
            n_vec++;
            if (got_q[i] !== {v, pla_fn(v)}) begin
                n_err++; $display("FAIL bp_order[%0d]: got src=%h data=%h, expected src=%h data=%h", i, got_q[i][12:5], got_q[i][4:0], v, pla_fn(v));
            end
        end
        got_q.delete(); del_q.delete();
        n_vec++; if (bus.out_count !== exp_cnt) begin n_err++; $display("FAIL bp_out_count: got %0d, expected %0d", bus.out_count, exp_cnt); end
    endtask

    task automatic test_streaming();
        int nvalid, first, last;
        logic [7:0] v;
        nvalid = 0; first = -1; last = -1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 70; c++) begin
            bus.in_valid = (c < 64);
            bus.in_data = 8'(c);
            cyc();
            if (bus.out_valid === 1'b1) begin
                nvalid++;
                if (first < 0) first = c;
                last = c;
            end
        end
        bus.in_valid = 1'b0;
        n_vec++; if (nvalid != 64 || (last - first + 1) != 64) begin
            n_err++; $display("FAIL stream_valid_run: got %0d valid cycles spanning %0d, expected 64 spanning 64", nvalid, last - first + 1);
        end
        n_vec++; if (got_q.size() != 64) begin n_err++; $display("FAIL stream_count: got %0d results, expected 64", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            v = 8'(i);
            n_vec++;
            if (got_q[i] !== {v, pla_fn(v)}) begin
                n_err++; $display("FAIL stream_result[%0d]: got src=%h data=%h, expected src=%h data=%h", i, got_q[i][12:5], got_q[i][4:0], v, pla_fn(v));
            end
        end
        got_q.delete(); del_q.delete();
        n_vec++; if (bus.out_count !== exp_cnt) begin n_err++; $display("FAIL stream_out_count: got %0d, expected %0d", bus.out_count, exp_cnt); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'h11 + 8'(k);
            cyc();
        end
        n_vec++; if (bus.level !== 3'd3 || bus.out_valid !== 1'b1) begin
            n_err++; $display("FAIL flush_setup: got level=%0d valid=%b, expected level=3 valid=1", bus.level, bus.out_valid);
        end
        bus.flush = 1'b1;
        bus.in_data = 8'hEE;
        cyc();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        n_vec++; if (bus.level !== 3'd0) begin n_err++; $display("FAIL flush_level: got %0d, expected 0", bus.level); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b, expected 0", bus.out_valid); end
        n_vec++; if (bus.pla_x !== 8'h00) begin n_err++; $display("FAIL flush_pla_x: got %h, expected 00", bus.pla_x); end
        bus.out_ready = 1'b1;
        repeat (5) cyc();
        n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL flush_leak: got %0d results, expected 0", got_q.size()); end
        bus.in_valid = 1'b1;
        bus.in_data = 8'h3C;
        cyc();
        bus.in_valid = 1'b0;
        repeat (4) cyc();
        n_vec++; if (got_q.size() != 1 || got_q[0] !== {8'h3C, pla_fn(8'h3C)}) begin
            n_err++; $display("FAIL flush_recover: got %0d results first=%h, expected 1 result %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 13'h0, {8'h3C, pla_fn(8'h3C)});
        end
        got_q.delete(); del_q.delete();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush = ($urandom_range(0, 39) == 0);
            cyc();
        end
        idle_inputs();
        bus.out_ready = 1'b1;
        repeat (10) cyc();
        for (int i = 0; i < got_q.size(); i++) begin
            n_vec++;
            if (del_q[i][8] || got_q[i] !== {del_q[i][7:0], pla_fn(del_q[i][7:0])}) begin
                n_err++; $display("FAIL random_result[%0d]: got src=%h data=%h, expected src=%h data=%h", i, got_q[i][12:5], got_q[i][4:0], del_q[i][7:0], pla_fn(del_q[i][7:0]));
            end
        end
        got_q.delete(); del_q.delete();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL random_undelivered: got %0d pending, expected 0", exp_q.size()); end
        n_vec++; if (bus.level !== 3'd0) begin n_err++; $display("FAIL random_level: got %0d, expected 0", bus.level); end
        n_vec++; if (bus.out_count !== exp_cnt) begin n_err++; $display("FAIL random_out_count: got %0d, expected %0d", bus.out_count, exp_cnt); end
    endtask

    task automatic test_async_reset();
        logic done;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'h21 + 8'(k);
            cyc();
        end
        bus.in_valid = 1'b0;
        n_vec++; if (bus.level !== 3'd2) begin n_err++; $display("FAIL areset_setup: got level=%0d, expected 2", bus.level); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.level !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 5'h00 || bus.out_src !== 8'h00 ||
                     bus.out_count !== 16'h0000 || bus.pla_x !== 8'h00 || bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL areset_outputs: got level=%0d valid=%b data=%h src=%h count=%h pla_x=%h in_ready=%b, expected all zero",
                              bus.level, bus.out_valid, bus.out_data, bus.out_src, bus.out_count, bus.pla_x, bus.in_ready);
        end
        cyc();
        rst_n = 1'b1;
        got_q.delete(); del_q.delete();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'hA5;
        cyc();
        bus.in_valid = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            cyc();
            done = (got_q.size() > 0);
        end
        n_vec++; if (!done || got_q[0] !== {8'hA5, pla_fn(8'hA5)}) begin
            n_err++; $display("FAIL areset_first_result: got %h (delivered=%b), expected %h", done ? got_q[0] : 13'h0, done, {8'hA5, pla_fn(8'hA5)});
        end
        got_q.delete(); del_q.delete();
    endtask

    task automatic test_counter_wrap();
        logic reached;
        reached = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 70000 && !reached; c++) begin
            if (exp_cnt == 16'hFFFF) begin
                reached = 1'b1;
            end else begin
                bus.in_data = 8'($urandom);
                cyc();
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        n_vec++; if (!reached) begin n_err++; $display("FAIL wrap_preload: got %0d handshakes, expected 65535", exp_cnt); end
        n_vec++; if (bus.out_count !== 16'hFFFF || bus.out_valid !== 1'b1) begin
            n_err++; $display("FAIL wrap_preload_count: got count=%h valid=%b, expected count=ffff valid=1", bus.out_count, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        n_vec++; if (bus.out_count !== 16'h0000) begin n_err++; $display("FAIL wrap_count: got %h, expected 0000", bus.out_count); end
        bus.out_ready = 1'b1;
        repeat (8) cyc();
        for (int i = 0; i < got_q.size(); i++) begin
            n_vec++;
            if (del_q[i][8] || got_q[i] !== {del_q[i][7:0], pla_fn(del_q[i][7:0])}) begin
                n_err++; $display("FAIL wrap_result[%0d]: got src=%h data=%h, expected src=%h data=%h", i, got_q[i][12:5], got_q[i][4:0], del_q[i][7:0], pla_fn(del_q[i][7:0]));
            end
        end
        got_q.delete(); del_q.delete();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_flush();
        test_random();
        test_async_reset();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
